pc_unit: RTL and testbench
==========================

# pc_unit

Program-counter and next-address stage of the processor. The branch offset, already scaled ×4 by the shift-left-2 stage, enters here directly. The block holds the PC, runs the instruction-fetch handshake with instruction memory, and latches the fetched word for decode. It selects the next PC from four sources, in priority order: jr target, jump target, taken-branch target, PC+4.

## Interface
Parameters:
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
- endereco_deslocado  in  32  sign-extended branch offset shifted left 2 (byte offset).
- branch  in  1  current instruction is a conditional branch (beq).
- zero  in  1  ALU zero flag for the current instruction.
- jump  in  1  current instruction is j/jal.
- jump_target  in  26  instruction bits [25:0].
- jr  in  1  current instruction is jr.
- reg_addr  in  32  register-file value for jr.
- stall  in  1  hold PC and state; no fetch issue or PC update.
- fetch_ack  in  1  instruction memory has valid data on instr_in.
- instr_in  in  32  instruction word from memory.
- pc_out  out  32  current PC (fetch address).
- pc_mais_4  out  32  pc_out + 4.
- fetch_req  out  1  fetch request to instruction memory.
- instr_out  out  32  latched instruction for decode.
- instr_valid  out  1  instr_out valid; execute cycle.
- misaligned  out  1  sticky flag: a selected next PC had bits [1:0] ≠ 0.

## Operation
- State machine has three states:
  - RESET_ST: entered while reset=0; no outputs active.
  - FETCH: fetch_req=1; waits for fetch_ack.
  - EXEC: instr_valid=1 for exactly one cycle.
- Transitions:
  - RESET_ST → FETCH on the first edge with reset=1.
  - FETCH → EXEC on an edge with fetch_ack=1 and stall=0. instr_in is latched into instr_out on that edge.
  - FETCH stays in FETCH while fetch_ack=0 or stall=1.
  - EXEC → FETCH on an edge with stall=0. pc_out is loaded with next_pc on that edge.
  - EXEC stays in EXEC while stall=1. pc_out, instr_out and instr_valid hold.
- next_pc selection (all sums mod 2^32, wrap-around silent):
  - jr=1: reg_addr.
  - else jump=1: {pc_mais_4[31:28], jump_target, 2'b00}.
  - else branch & zero: pc_mais_4 + endereco_deslocado.
  - else: pc_mais_4.
- Multiple selects asserted together: the priority above decides; no error is raised.
- pc_mais_4 is combinational from pc_out. At pc_out=32'hFFFF_FFFC it equals 32'h0000_0000.
- misaligned:
  - Set on the EXEC→FETCH edge when next_pc[1:0] ≠ 0.
  - The PC is still loaded with next_pc as selected; it is not forced to alignment.
  - Cleared only by reset.
- fetch_ack arriving in EXEC or RESET_ST is ignored.

## Timing
- Reset values:
  - pc_out = RESET_ADDR; pc_mais_4 = RESET_ADDR+4.
  - fetch_req = 0; instr_out = 0; instr_valid = 0; misaligned = 0.
  - State = RESET_ST.
- Reset mid-operation: the next edge with reset=0 forces all reset values regardless of state, stall or fetch_ack.
- Minimum instruction period is 2 cycles (FETCH with immediate ack, then EXEC).
- fetch_req:
  - Registered; rises on the first edge after reset release.
  - Stays high through a stalled FETCH.
  - Falls on the ack edge.
- instr_out is updated only on the FETCH→EXEC edge; it is stable for the whole EXEC cycle(s).
- Control inputs (branch, zero, jump, jr, reg_addr, endereco_deslocado, jump_target) are sampled only on the EXEC→FETCH edge.
- New pc_out is visible the cycle after EXEC, coinciding with fetch_req=1.

## Test plan
- Reset and first fetch:
  - Stimulus: reset=0 for 2 cycles, then 1; fetch_ack=1 in cycle 2 after release with instr_in=32'h2008_0005.
  - Required: pc_out=0, fetch_req=1 from cycle 1; instr_valid=1 for one cycle with instr_out=32'h2008_0005; next pc_out=4.
- Branch taken and not taken:
  - Stimulus: pc_out=32'h40, branch=1, endereco_deslocado=32'hFFFF_FFF0.
  - Required: zero=1 gives next pc_out=32'h34; zero=0 gives next pc_out=32'h44.
- Jump and jr priority:
  - Stimulus: pc_out=32'h1000_0008, jump=1, jump_target=26'h10, jr=0.
  - Required: next pc_out=32'h1000_0040.
  - Stimulus: the same cycle with jr=1, reg_addr=32'h200.
  - Required: next pc_out=32'h200.
- Stall:
  - Stimulus: stall=1 for 3 cycles in FETCH with fetch_ack=1, then 3 cycles in EXEC.
  - Required: state, pc_out and instr_out unchanged throughout; instr_valid stays 1 during the EXEC stall; advance on the first stall=0 edge.
- Wrap-around and misaligned:
  - Stimulus: pc_out=32'hFFFF_FFFC, no branch.
  - Required: next pc_out=0.
  - Stimulus: jr with reg_addr=32'h102.
  - Required: pc_out=32'h102 and misaligned=1 until reset.
- Reset mid-wait:
  - Stimulus: assert reset=0 in FETCH with fetch_ack=0.
  - Required: next cycle pc_out=RESET_ADDR, fetch_req=0, instr_valid=0; a late fetch_ack is ignored.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter / next-address stage: holds the PC, runs the fetch handshake
// with instruction memory and presents the latched instruction to decode.
module pc_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] endereco_deslocado,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jr,
    input  logic [31:0] reg_addr,
    input  logic        stall,
    input  logic        fetch_ack,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] pc_mais_4,
    output logic        fetch_req,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        RESET_ST = 2'd0,
        FETCH    = 2'd1,
        EXEC     = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;
    logic        misaligned_reg;
    logic [31:0] next_pc;
    logic        load_instr;
    logic        load_pc;

    assign pc_mais_4 = pc_reg + 32'd4;

    // jr > jump > taken branch > sequential
    always_comb begin
        next_pc = pc_mais_4;
        if (jr)
            next_pc = reg_addr;
        else if (jump)
            next_pc = {pc_mais_4[31:28], jump_target, 2'b00};
        else if (branch && zero)
            next_pc = pc_mais_4 + endereco_deslocado;
    end

    always_comb begin
        state_next = state_reg;
        load_instr = 1'b0;
        load_pc    = 1'b0;
        case (state_reg)
            RESET_ST: state_next = FETCH;
            FETCH: begin
                if (fetch_ack && !stall) begin
                    state_next = EXEC;
                    load_instr = 1'b1;
                end
            end
            EXEC: begin
                if (!stall) begin
                    state_next = FETCH;
                    load_pc    = 1'b1;
                end
            end
            default: state_next = RESET_ST;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg      <= RESET_ST;
            pc_reg         <= RESET_ADDR;
            instr_reg      <= 32'd0;
            misaligned_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load_instr)
                instr_reg <= instr_in;
            if (load_pc)
                pc_reg <= next_pc;
            // Misaligned targets are still taken; the flag just records it.
            if (load_pc && (next_pc[1:0] != 2'b00))
                misaligned_reg <= 1'b1;
        end
    end

    assign pc_out      = pc_reg;
    assign instr_out   = instr_reg;
    assign fetch_req   = (state_reg == FETCH);
    assign instr_valid = (state_reg == EXEC);
    assign misaligned  = misaligned_reg;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: fetch handshake, next-PC selection, stall,
// wrap-around, misaligned flag and reset mid-fetch.
module tb_pc_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] endereco_deslocado;
    logic        branch, zero, jump, jr, stall, fetch_ack;
    logic [25:0] jump_target;
    logic [31:0] reg_addr, instr_in;
    logic [31:0] pc_out, pc_mais_4, instr_out;
    logic        fetch_req, instr_valid, misaligned;

    int n_cmp = 0;
    int n_mis = 0;

    pc_unit #(.RESET_ADDR(32'h0000_0000)) dut (
        .clock              (clock),
        .reset              (reset),
        .endereco_deslocado (endereco_deslocado),
        .branch             (branch),
        .zero               (zero),
        .jump               (jump),
        .jump_target        (jump_target),
        .jr                 (jr),
        .reg_addr           (reg_addr),
        .stall              (stall),
        .fetch_ack          (fetch_ack),
        .instr_in           (instr_in),
        .pc_out             (pc_out),
        .pc_mais_4          (pc_mais_4),
        .fetch_req          (fetch_req),
        .instr_out          (instr_out),
        .instr_valid        (instr_valid),
        .misaligned         (misaligned)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_ctrl();
        branch = 0; zero = 0; jump = 0; jr = 0;
        jump_target = 26'd0; reg_addr = 32'd0; endereco_deslocado = 32'd0;
    endtask

    // One full instruction from FETCH: immediate ack, then EXEC with the given controls.
    task automatic run_instr(input string tag, input logic [31:0] word,
                             input logic c_jr, input logic [31:0] c_reg,
                             input logic c_jump, input logic [25:0] c_jt,
                             input logic c_br, input logic c_zero, input logic [31:0] c_off,
                             input logic [31:0] exp_pc);
        fetch_ack = 1; instr_in = word;
        tick();
        check({tag, ".valid"}, 32'(instr_valid), 32'd1);
        check({tag, ".instr"}, instr_out, word);
        fetch_ack = 0;
        jr = c_jr; reg_addr = c_reg; jump = c_jump; jump_target = c_jt;
        branch = c_br; zero = c_zero; endereco_deslocado = c_off;
        tick();
        clear_ctrl();
        check({tag, ".pc"}, pc_out, exp_pc);
        check({tag, ".req"}, 32'(fetch_req), 32'd1);
    endtask

    initial begin
        reset = 0; stall = 0; fetch_ack = 0; instr_in = 32'd0;
        clear_ctrl();
        tick(); tick();
        check("rst.pc", pc_out, 32'h0);
        check("rst.pc4", pc_mais_4, 32'h4);
        check("rst.req", 32'(fetch_req), 32'd0);
        check("rst.valid", 32'(instr_valid), 32'd0);
        check("rst.instr", instr_out, 32'h0);
        check("rst.mis", 32'(misaligned), 32'd0);

        reset = 1;
        tick();
        check("c1.req", 32'(fetch_req), 32'd1);
        check("c1.pc", pc_out, 32'h0);
        tick();
        check("c2.req_wait", 32'(fetch_req), 32'd1);
        fetch_ack = 1; instr_in = 32'h2008_0005;
        tick();
        check("first.valid", 32'(instr_valid), 32'd1);
        check("first.instr", instr_out, 32'h2008_0005);
        check("first.req_fall", 32'(fetch_req), 32'd0);
        fetch_ack = 0;
        tick();
        check("first.valid_1cyc", 32'(instr_valid), 32'd0);
        check("first.pc", pc_out, 32'h4);

        // Branch taken / not taken from pc 0x40
        run_instr("jr40a", 32'h1, 1, 32'h40, 0, 26'h0, 0, 0, 32'h0, 32'h40);
        run_instr("beq_t", 32'h2, 0, 32'h0, 0, 26'h0, 1, 1, 32'hFFFF_FFF0, 32'h34);
        run_instr("jr40b", 32'h3, 1, 32'h40, 0, 26'h0, 0, 0, 32'h0, 32'h40);
        run_instr("beq_n", 32'h4, 0, 32'h0, 0, 26'h0, 1, 0, 32'hFFFF_FFF0, 32'h44);

        // Jump, then jr overriding jump
        run_instr("jr1k", 32'h5, 1, 32'h1000_0008, 0, 26'h0, 0, 0, 32'h0, 32'h1000_0008);
        run_instr("jump", 32'h6, 0, 32'h0, 1, 26'h10, 0, 0, 32'h0, 32'h1000_0040);
        run_instr("jr1k2", 32'h7, 1, 32'h1000_0008, 0, 26'h0, 0, 0, 32'h0, 32'h1000_0008);
        run_instr("jr_pri", 32'h8, 1, 32'h200, 1, 26'h10, 1, 1, 32'h10, 32'h200);

        // Stall in FETCH with ack asserted
        stall = 1; fetch_ack = 1; instr_in = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stf.req", 32'(fetch_req), 32'd1);
            check("stf.valid", 32'(instr_valid), 32'd0);
            check("stf.pc", pc_out, 32'h200);
            check("stf.instr", instr_out, 32'h8);
        end
        stall = 0;
        tick();
        check("stf.adv_valid", 32'(instr_valid), 32'd1);
        check("stf.adv_instr", instr_out, 32'hDEAD_BEEF);
        // Stall in EXEC; ack in EXEC must be ignored
        stall = 1; instr_in = 32'h1234_5678; jr = 1; reg_addr = 32'h300;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ste.valid", 32'(instr_valid), 32'd1);
            check("ste.pc", pc_out, 32'h200);
            check("ste.instr", instr_out, 32'hDEAD_BEEF);
        end
        stall = 0;
        tick();
        fetch_ack = 0; clear_ctrl();
        check("ste.adv_pc", pc_out, 32'h300);
        check("ste.adv_req", 32'(fetch_req), 32'd1);
        check("ste.instr_hold", instr_out, 32'hDEAD_BEEF);

        // Wrap-around
        run_instr("jrtop", 32'h9, 1, 32'hFFFF_FFFC, 0, 26'h0, 0, 0, 32'h0, 32'hFFFF_FFFC);
        check("wrap.pc4", pc_mais_4, 32'h0);
        run_instr("wrap", 32'hA, 0, 32'h0, 0, 26'h0, 0, 0, 32'h0, 32'h0);
        check("wrap.mis", 32'(misaligned), 32'd0);

        // Misaligned jr target is taken and flagged stickily
        run_instr("jr102", 32'hB, 1, 32'h102, 0, 26'h0, 0, 0, 32'h0, 32'h102);
        check("mis.set", 32'(misaligned), 32'd1);
        run_instr("seq", 32'hC, 0, 32'h0, 0, 26'h0, 0, 0, 32'h0, 32'h106);
        check("mis.sticky", 32'(misaligned), 32'd1);

        // Reset while waiting in FETCH
        fetch_ack = 0; reset = 0;
        tick();
        check("mrst.pc", pc_out, 32'h0);
        check("mrst.req", 32'(fetch_req), 32'd0);
        check("mrst.valid", 32'(instr_valid), 32'd0);
        check("mrst.mis", 32'(misaligned), 32'd0);
        check("mrst.instr", instr_out, 32'h0);
        fetch_ack = 1; instr_in = 32'hCAFE_F00D;
        tick();
        check("late.valid", 32'(instr_valid), 32'd0);
        check("late.instr", instr_out, 32'h0);
        reset = 1;
        tick();
        check("late.req", 32'(fetch_req), 32'd1);
        check("late.valid2", 32'(instr_valid), 32'd0);
        check("late.instr2", instr_out, 32'h0);
        fetch_ack = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
